piso_tx: RTL and testbench

Parallel-in serial-out transmitter. It is the transmit-side counterpart of the team's SIPO receiver.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled cycle.
- Marks each serial bit with valid, first and last qualifiers.
- A one-entry holding buffer allows back-to-back words with no idle bit slot between them.
- Sits between a word-oriented producer and a bit-serial link or a downstream SIPO.

---
 rtl/piso_tx.sv | 184 ++++++++++++++++++
 tb/tb_piso_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-entry holding buffer so that
// back-to-back words stream out with no idle bit slot between frames.
module piso_tx #(
  parameter int DATA_WIDTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] pin_data,
  input  logic                  pin_valid,
  output logic                  pin_ready,
  input  logic                  shift_en,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  sout_first,
  output logic                  sout_last,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;

  logic sout_q, sout_d;
  logic sout_valid_q, sout_valid_d;
  logic sout_first_q, sout_first_d;
  logic sout_last_q, sout_last_d;
  logic busy_q, busy_d;
  logic pin_ready_q, pin_ready_d;

  logic accept_s;
  logic last_bit_s;

  // Advance the shifter by one bit toward the output end.
  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      shift_word = {w[DATA_WIDTH-2:0], 1'b0};
    end else begin
      shift_word = {1'b0, w[DATA_WIDTH-1:1]};
    end
  endfunction

  // The bit currently presented on the serial line.
  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      out_bit = w[DATA_WIDTH-1];
    end else begin
      out_bit = w[0];
    end
  endfunction

  assign accept_s   = pin_valid && !hold_full_q;
  assign last_bit_s = (cnt_q == CNT_LAST);

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      shreg_q      <= {DATA_WIDTH{1'b0}};
      hold_q       <= {DATA_WIDTH{1'b0}};
      hold_full_q  <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_first_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      pin_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_first_q <= sout_first_d;
      sout_last_q  <= sout_last_d;
      busy_q       <= busy_d;
      pin_ready_q  <= pin_ready_d;
    end
  end

  // Next state: word routing, shifting and hold-buffer management.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_ZERO;
          shreg_d = pin_data;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (shift_en) begin
          if (last_bit_s) begin
            // A buffered word outranks a fresh one; both cannot coexist anyway.
            if (hold_full_q) begin
              shreg_d     = hold_q;
              cnt_d       = CNT_ZERO;
              hold_full_d = 1'b0;
            end else if (accept_s) begin
              shreg_d = pin_data;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end
          end else begin
            shreg_d = shift_word(shreg_q);
            cnt_d   = cnt_q + CNT_ONE;
            if (accept_s) begin
              hold_d      = pin_data;
              hold_full_d = 1'b1;
            end else begin
              hold_full_d = hold_full_q;
            end
          end
        end else begin
          if (accept_s) begin
            hold_d      = pin_data;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = CNT_ZERO;
        hold_full_d = 1'b0;
      end
    endcase
  end

  // Output decode from next state so every output leaves a flop.
  always_comb begin
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    sout_first_d = 1'b0;
    sout_last_d  = 1'b0;
    if (state_d == ST_SHIFT) begin
      sout_d       = out_bit(shreg_d);
      sout_valid_d = 1'b1;
      sout_first_d = (cnt_d == CNT_ZERO);
      sout_last_d  = (cnt_d == CNT_LAST);
    end else begin
      sout_d       = 1'b0;
      sout_valid_d = 1'b0;
    end
    busy_d      = (state_d == ST_SHIFT) || hold_full_d;
    pin_ready_d = !hold_full_d;
  end

  assign pin_ready  = pin_ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_first = sout_first_q;
  assign sout_last  = sout_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: MSB-first and LSB-first instances share
// stimulus and are checked against a word-queue reference model.
module tb_piso_tx;

  localparam int W = 4;

  logic         clk;
  logic         resetn;
  logic [W-1:0] pin_data;
  logic         pin_valid;
  logic         shift_en;

  logic m_ready, m_sout, m_valid, m_first, m_last, m_busy;
  logic l_ready, l_sout, l_valid, l_first, l_last, l_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: queue of pending words (front = on the wire), bit index of front.
  logic [W-1:0] mq[$];
  int           midx = 0;

  piso_tx #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .resetn(resetn), .pin_data(pin_data), .pin_valid(pin_valid),
    .pin_ready(m_ready), .shift_en(shift_en), .sout(m_sout), .sout_valid(m_valid),
    .sout_first(m_first), .sout_last(m_last), .busy(m_busy)
  );

  piso_tx #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .resetn(resetn), .pin_data(pin_data), .pin_valid(pin_valid),
    .pin_ready(l_ready), .shift_en(shift_en), .sout(l_sout), .sout_valid(l_valid),
    .sout_first(l_first), .sout_last(l_last), .busy(l_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic v, input logic [W-1:0] d, input logic se);
    bit acc;
    if (!rst) begin
      mq.delete();
      midx = 0;
    end else begin
      acc = v && (mq.size() < 2);
      if (mq.size() > 0 && se) begin
        midx++;
        if (midx == W) begin
          void'(mq.pop_front());
          midx = 0;
        end
      end
      if (acc) mq.push_back(d);
    end
  endtask

  function automatic logic exp_bit(input bit msb);
    logic [W-1:0] w;
    if (mq.size() == 0) return 1'b0;
    w = mq[0];
    return msb ? w[W-1-midx] : w[midx];
  endfunction

  task automatic check_model();
    logic act_any;
    act_any = (mq.size() > 0);
    chk("m_ready", m_ready, mq.size() < 2);
    chk("m_busy",  m_busy,  act_any);
    chk("m_valid", m_valid, act_any);
    chk("m_sout",  m_sout,  exp_bit(1'b1));
    chk("m_first", m_first, act_any && midx == 0);
    chk("m_last",  m_last,  act_any && midx == W-1);
    chk("l_ready", l_ready, mq.size() < 2);
    chk("l_busy",  l_busy,  act_any);
    chk("l_valid", l_valid, act_any);
    chk("l_sout",  l_sout,  exp_bit(1'b0));
    chk("l_first", l_first, act_any && midx == 0);
    chk("l_last",  l_last,  act_any && midx == W-1);
  endtask

  task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input logic se);
    resetn    = rst;
    pin_valid = v;
    pin_data  = d;
    shift_en  = se;
    @(posedge clk);
    model_edge(rst, v, d, se);
    #1;
    check_model();
  endtask

  typedef struct {
    logic         rst;
    logic         v;
    logic [W-1:0] d;
    logic         se;
    logic         ready;
    logic         busy;
    logic         sv;
    logic         s;
    logic         f;
    logic         l;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic rst, input logic v, input logic [W-1:0] d, input logic se,
                              input logic ready, input logic busy, input logic sv,
                              input logic s, input logic f, input logic l);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.se = se;
    r.ready = ready; r.busy = busy; r.sv = sv; r.s = s; r.f = f; r.l = l;
    return r;
  endfunction

  initial begin
    logic [3:0] lsb_seq;
    int         frame_len;
    int         leak;

    resetn = 1'b0; pin_valid = 1'b0; pin_data = 4'h0; shift_en = 1'b0;

    // Reset with valid high, single MSB frame 1011, back-to-back A then 5.
    tbl[0]  = mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[6]  = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[15] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    lsb_seq = 4'h0;
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].se);
      chk($sformatf("tbl%0d_ready", i), m_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_busy", i),  m_busy,  tbl[i].busy);
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].sv);
      chk($sformatf("tbl%0d_sout", i),  m_sout,  tbl[i].s);
      chk($sformatf("tbl%0d_first", i), m_first, tbl[i].f);
      chk($sformatf("tbl%0d_last", i),  m_last,  tbl[i].l);
      if (i >= 2 && i <= 5) lsb_seq = {lsb_seq[2:0], l_sout};
    end
    chk("lsb_first_1011", lsb_seq, 4'b1101);

    // Stall three cycles while bit index 2 of 0110 is on the wire.
    frame_len = 0;
    step(1'b1, 1'b1, 4'h6, 1'b1); frame_len += m_valid;
    step(1'b1, 1'b0, 4'h0, 1'b1); frame_len += m_valid;
    step(1'b1, 1'b0, 4'h0, 1'b1); frame_len += m_valid;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h0, 1'b0); frame_len += m_valid;
      chk("stall_sout", m_sout, 1'b1);
      chk("stall_valid", m_valid, 1'b1);
    end
    step(1'b1, 1'b0, 4'h0, 1'b1); frame_len += m_valid;
    chk("post_stall_last", m_last, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b1); frame_len += m_valid;
    chk("stall_frame_len", frame_len, 7);

    // Reset mid-frame: C on the wire, 3 buffered, neither may resurface.
    step(1'b1, 1'b1, 4'hC, 1'b1);
    step(1'b1, 1'b1, 4'h3, 1'b1);
    chk("pre_rst_hold", m_ready, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("rst_mid_valid", m_valid, 1'b0);
    chk("rst_mid_ready", m_ready, 1'b1);
    chk("rst_mid_busy",  m_busy,  1'b0);
    leak = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 4'h0, 1'b1);
      leak += m_valid + l_valid;
    end
    chk("rst_mid_no_leak", leak, 0);

    // Random traffic, stalls and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
